mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
- Multi-cycle control FSM that drives the CPU datapath: PC, instruction register, register file, ALU, data memory and the ADR/BDR/ALUoutDR/DBDR latches.
- Decodes the 6-bit opcode held in the IR and sequences each instruction through the IF/ID/EXE/MEM/WB states.
- For each state it asserts the write enables and mux selects the datapath consumes.
- Instance sits inside CPU, directly upstream of the datapath.

Parameters:
- OP_HALT, 6'b111111, opcode that parks the FSM in HALT.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset.
- op  input  6  IR[31:26].
- zero  input  1  ALU result == 0.
- sign  input  1  ALU result bit 31.
- PCWre  output  1  PC load enable.
- IRWre  output  1  IR load enable.
- InsMemRw  output  1  instruction memory read; constant 1.
- PcSrc  output  2  00 PC+4, 01 PC+4+(ext<<2), 10 rs, 11 {PC4[31:28],addr,2'b00}.
- RegDst  output  2  00 $31, 01 rt, 10 rd.
- RegWre  output  1  register file write enable.
- WrRegDSrc  output  1  0 PC+4 (jal), 1 DBDR.
- ALUSrcB  output  1  0 BDR, 1 extendResult.
- ExtSel  output  1  0 zero-extend, 1 sign-extend.
- ALUOp  output  3  000 A+B, 001 A-B, 011 A|B, 100 A&B, 101 unsigned A<B, 110 signed A<B.
- mRD  output  1  data memory read.
- mWR  output  1  data memory write.
- DBDataSrc  output  1  0 ALU result, 1 memory data.
- state  output  3  current state, for debug.
- halted  output  1  1 while in HALT.

Behaviour:
- Opcodes:
  - R/ALU: add 000000, sub 000001, or 010000, and 010001, slt 100110.
  - Immediate: addi 000010, ori 010010, sltiu 100111.
  - Memory: sw 110000, lw 110001.
  - Branch: beq 110100, bne 110101, bltz 110110.
  - Jump: j 111000, jr 111001, jal 111010.
  - Halt: 111111.
  - Any other opcode is a nop.
- State encodings: IF 000, ID 001, EXE_LS 010, MEM 011, WB_LD 100, EXE_BR 101, EXE_AL 110, WB_AL 111. HALT reuses 001 with the internal halted flag set.
- Reset: when reset==0 at a posedge, state<=IF and halted<=0. While reset==0, PCWre, IRWre, RegWre, mRD and mWR are forced to 0 combinationally. A reset asserted mid-instruction aborts it and no write completes on that edge.
- Transitions:
  - IF -> ID.
  - ID -> IF for j, jr, jal and nop.
  - ID -> HALT for OP_HALT.
  - ID -> EXE_BR for beq, bne, bltz.
  - ID -> EXE_LS for lw, sw.
  - ID -> EXE_AL for everything else.
  - EXE_AL -> WB_AL -> IF.
  - EXE_BR -> IF.
  - EXE_LS -> MEM.
  - MEM -> IF for sw; MEM -> WB_LD for lw.
  - WB_LD -> IF.
  - HALT -> HALT until reset.
- Latency in cycles: j/jr/jal/nop 2, branch 3, ALU 4, sw 4, lw 5.
- Outputs are combinational from state and op. op is stable from ID onward because IRWre is high only in IF.
- Defaults: all enables 0, PcSrc=00, RegDst=01, WrRegDSrc=1, ALUSrcB=0, ExtSel=1, ALUOp=000, DBDataSrc=0.
- IF: IRWre=1.
- PCWre=1 exactly in the final state of each instruction (the one transitioning to IF), so the PC updates on that edge. PCWre=0 in HALT.
- ID, jump group:
  - j: PcSrc=11.
  - jr: PcSrc=10.
  - jal: PcSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0.
- EXE_AL / WB_AL:
  - ALUSrcB=1 for immediates.
  - ExtSel=0 for ori, 1 otherwise.
  - ALUOp per opcode: sltiu->101, slt->110.
  - WB_AL additionally: RegWre=1, RegDst = 10 for R-type, 01 for immediates.
- EXE_BR: ALUOp=001, ALUSrcB=0. PcSrc=01 when:
  - beq && zero;
  - bne && !zero;
  - bltz && sign.
  Otherwise PcSrc=00.
- EXE_LS: ALUSrcB=1, ExtSel=1, ALUOp=000.
- MEM: mRD=1 for lw; mWR=1 for sw (PCWre=1 for sw).
- WB_LD: DBDataSrc=1, RegWre=1, RegDst=01, WrRegDSrc=1.
- Only one of mRD/mWR may be high, and never outside MEM.

Test Plan:
- Hold reset=0 for 2 edges, then release with op=add -> state=000, IRWre=1, all other enables 0; states 000->001->110->111->000; RegWre=1, RegDst=10 in WB_AL; PCWre high only in WB_AL.
- op=lw -> 5 cycles; mRD=1 only in MEM; in WB_LD: DBDataSrc=1, RegWre=1, RegDst=01.
- op=sw -> 4 cycles; mWR=1 and PCWre=1 in MEM; RegWre never 1.
- op=beq with zero=1 in EXE_BR -> PcSrc=01, PCWre=1. Repeat with zero=0 -> PcSrc=00. Also cover bne with zero=0 -> PcSrc=01, and bltz with sign=1 -> PcSrc=01.
- op=jal -> ID: PcSrc=11, RegDst=00, WrRegDSrc=0, RegWre=1, PCWre=1; next state IF.
- op=111111 -> halted=1 from the cycle after ID; PCWre=0 for 10 cycles. Then reset=0 -> state=000, halted=0. Also pulse reset=0 during MEM of sw -> mWR=0 on that cycle and state=000 after the edge.

Source files
------------

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle control FSM for the CPU datapath.
// Decodes the IR opcode and steps each instruction through IF/ID/EXE/MEM/WB,
// driving the datapath write enables and mux selects for every state.
//
// Ports:
//   clk, reset (sync, active-low)   - clock and reset
//   op[5:0]                         - IR[31:26]
//   zero, sign                      - ALU result == 0, ALU result bit 31
//   PCWre, IRWre, RegWre            - PC / IR / register file write enables
//   InsMemRw                        - instruction memory read (always 1)
//   PcSrc[1:0], RegDst[1:0]         - next-PC select, destination register select
//   WrRegDSrc, ALUSrcB, ExtSel      - write-back source, ALU B source, extender mode
//   ALUOp[2:0]                      - ALU function
//   mRD, mWR, DBDataSrc             - data memory read/write, DB bus source
//   state[2:0], halted              - debug view of the FSM
module mc_control_unit #(
  parameter logic [5:0] OP_HALT = 6'b111111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       sign,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRw,
  output logic [1:0] PcSrc,
  output logic [1:0] RegDst,
  output logic       RegWre,
  output logic       WrRegDSrc,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic [2:0] ALUOp,
  output logic       mRD,
  output logic       mWR,
  output logic       DBDataSrc,
  output logic [2:0] state,
  output logic       halted
);

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_OR    = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLTIU = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  state_t curState;
  logic   isRType;
  logic   isImm;
  logic   isJump;

  assign state    = curState;
  assign InsMemRw = 1'b1;

  always_comb begin
    isRType = (op == OP_ADD) || (op == OP_SUB) || (op == OP_OR) ||
              (op == OP_AND) || (op == OP_SLT);
    isImm   = (op == OP_ADDI) || (op == OP_ORI) || (op == OP_SLTIU);
    isJump  = (op == OP_J) || (op == OP_JR) || (op == OP_JAL);
  end

  // HALT has no encoding of its own: it is ID with the halted flag set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      curState <= S_IF;
      halted   <= 1'b0;
    end else begin
      case (curState)
        S_IF: curState <= S_ID;
        S_ID: begin
          if (!halted) begin
            if (op == OP_HALT)
              halted <= 1'b1;
            else if (op == OP_BEQ || op == OP_BNE || op == OP_BLTZ)
              curState <= S_EXE_BR;
            else if (op == OP_LW || op == OP_SW)
              curState <= S_EXE_LS;
            else if (isRType || isImm)
              curState <= S_EXE_AL;
            else
              curState <= S_IF;
          end
        end
        S_EXE_AL: curState <= S_WB_AL;
        S_WB_AL:  curState <= S_IF;
        S_EXE_BR: curState <= S_IF;
        S_EXE_LS: curState <= S_MEM;
        S_MEM:    curState <= (op == OP_SW) ? S_IF : S_WB_LD;
        S_WB_LD:  curState <= S_IF;
        default:  curState <= S_IF;
      endcase
    end
  end

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    PcSrc     = 2'b00;
    RegDst    = 2'b01;
    WrRegDSrc = 1'b1;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b1;
    ALUOp     = 3'b000;
    DBDataSrc = 1'b0;

    case (curState)
      S_IF: IRWre = 1'b1;
      S_ID: begin
        if (!halted && op != OP_HALT && !isRType && !isImm &&
            op != OP_LW && op != OP_SW &&
            op != OP_BEQ && op != OP_BNE && op != OP_BLTZ) begin
          // jumps and nops retire here
          PCWre = 1'b1;
          if (op == OP_J) begin
            PcSrc = 2'b11;
          end else if (op == OP_JR) begin
            PcSrc = 2'b10;
          end else if (op == OP_JAL) begin
            PcSrc     = 2'b11;
            RegWre    = 1'b1;
            RegDst    = 2'b00;
            WrRegDSrc = 1'b0;
          end
        end
      end
      S_EXE_AL, S_WB_AL: begin
        ALUSrcB = isImm;
        ExtSel  = (op != OP_ORI);
        case (op)
          OP_SUB:        ALUOp = 3'b001;
          OP_OR, OP_ORI: ALUOp = 3'b011;
          OP_AND:        ALUOp = 3'b100;
          OP_SLTIU:      ALUOp = 3'b101;
          OP_SLT:        ALUOp = 3'b110;
          default:       ALUOp = 3'b000;
        endcase
        if (curState == S_WB_AL) begin
          PCWre  = 1'b1;
          RegWre = 1'b1;
          RegDst = isRType ? 2'b10 : 2'b01;
        end
      end
      S_EXE_BR: begin
        PCWre = 1'b1;
        ALUOp = 3'b001;
        if ((op == OP_BEQ && zero) || (op == OP_BNE && !zero) ||
            (op == OP_BLTZ && sign))
          PcSrc = 2'b01;
      end
      S_EXE_LS: ALUSrcB = 1'b1;
      S_MEM: begin
        if (op == OP_SW) begin
          mWR   = 1'b1;
          PCWre = 1'b1;
        end else begin
          mRD = 1'b1;
        end
      end
      S_WB_LD: begin
        PCWre     = 1'b1;
        DBDataSrc = 1'b1;
        RegWre    = 1'b1;
      end
      default: ;
    endcase

    // reset low suppresses every write so an aborted instruction commits nothing
    if (!reset) begin
      PCWre  = 1'b0;
      IRWre  = 1'b0;
      RegWre = 1'b0;
      mRD    = 1'b0;
      mWR    = 1'b0;
    end
  end

  // isJump kept for readability of decode; referenced to keep it live
  logic unusedJump;
  assign unusedJump = isJump;

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       sign;
  logic       PCWre, IRWre, InsMemRw, RegWre, WrRegDSrc, ALUSrcB, ExtSel;
  logic       mRD, mWR, DBDataSrc, halted;
  logic [1:0] PcSrc, RegDst;
  logic [2:0] ALUOp, state;

  int unsigned checks = 0;
  int unsigned passes = 0;

  mc_control_unit #(.OP_HALT(6'b111111)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .sign(sign),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRw(InsMemRw), .PcSrc(PcSrc),
    .RegDst(RegDst), .RegWre(RegWre), .WrRegDSrc(WrRegDSrc),
    .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp), .mRD(mRD),
    .mWR(mWR), .DBDataSrc(DBDataSrc), .state(state), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic [2:0] aluOp;
    logic       srcB;
    logic       ext;
    logic [1:0] regDst;
  } aluVec_t;

  typedef struct {
    logic [5:0] op;
    logic       zero;
    logic       sign;
    logic [1:0] pcSrc;
  } brVec_t;

  typedef struct {
    logic [5:0] op;
    logic [1:0] pcSrc;
    logic       regWre;
    logic [1:0] regDst;
    logic       wrSrc;
  } jmpVec_t;

  // {state, halted, PCWre, IRWre, RegWre, mRD, mWR}
  function automatic logic [8:0] cw();
    return {state, halted, PCWre, IRWre, RegWre, mRD, mWR};
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      passes++;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic setOp(input logic [5:0] o, input logic z, input logic s);
    op   = o;
    zero = z;
    sign = s;
    #1;
  endtask

  aluVec_t aluTab[8] = '{
    '{6'b000000, 3'b000, 1'b0, 1'b1, 2'b10},
    '{6'b000001, 3'b001, 1'b0, 1'b1, 2'b10},
    '{6'b010000, 3'b011, 1'b0, 1'b1, 2'b10},
    '{6'b010001, 3'b100, 1'b0, 1'b1, 2'b10},
    '{6'b100110, 3'b110, 1'b0, 1'b1, 2'b10},
    '{6'b000010, 3'b000, 1'b1, 1'b1, 2'b01},
    '{6'b010010, 3'b011, 1'b1, 1'b0, 2'b01},
    '{6'b100111, 3'b101, 1'b1, 1'b1, 2'b01}
  };

  brVec_t brTab[6] = '{
    '{6'b110100, 1'b1, 1'b0, 2'b01},
    '{6'b110100, 1'b0, 1'b1, 2'b00},
    '{6'b110101, 1'b0, 1'b0, 2'b01},
    '{6'b110101, 1'b1, 1'b0, 2'b00},
    '{6'b110110, 1'b0, 1'b1, 2'b01},
    '{6'b110110, 1'b1, 1'b0, 2'b00}
  };

  jmpVec_t jmpTab[4] = '{
    '{6'b111000, 2'b11, 1'b0, 2'b01, 1'b1},
    '{6'b111001, 2'b10, 1'b0, 2'b01, 1'b1},
    '{6'b111010, 2'b11, 1'b1, 2'b00, 1'b0},
    '{6'b000011, 2'b00, 1'b0, 2'b01, 1'b1}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    op    = 6'b000000;
    zero  = 1'b0;
    sign  = 1'b0;
    tick();
    tick();
    checkVal("resetState", {23'd0, cw()}, {23'd0, 3'b000, 6'b000000});
    checkVal("insMemRw", {31'd0, InsMemRw}, 32'd1);
    reset = 1'b1;
    #1;

    // ALU group: IF, ID, EXE_AL, WB_AL
    for (int i = 0; i < 8; i++) begin
      setOp(aluTab[i].op, 1'b0, 1'b0);
      checkVal("aluIF", {23'd0, cw()}, {23'd0, 3'b000, 6'b001000});
      tick();
      checkVal("aluID", {23'd0, cw()}, {23'd0, 3'b001, 6'b000000});
      tick();
      checkVal("aluEXE", {23'd0, cw()}, {23'd0, 3'b110, 6'b000000});
      checkVal("aluOpExe", {29'd0, ALUOp}, {29'd0, aluTab[i].aluOp});
      checkVal("aluSrcB", {31'd0, ALUSrcB}, {31'd0, aluTab[i].srcB});
      checkVal("aluExt", {31'd0, ExtSel}, {31'd0, aluTab[i].ext});
      tick();
      checkVal("aluWB", {23'd0, cw()}, {23'd0, 3'b111, 6'b010100});
      checkVal("aluRegDst", {30'd0, RegDst}, {30'd0, aluTab[i].regDst});
      checkVal("aluOpWb", {29'd0, ALUOp}, {29'd0, aluTab[i].aluOp});
      tick();
    end

    // lw: 5 cycles
    setOp(6'b110001, 1'b0, 1'b0);
    checkVal("lwIF", {23'd0, cw()}, {23'd0, 3'b000, 6'b001000});
    tick();
    checkVal("lwID", {23'd0, cw()}, {23'd0, 3'b001, 6'b000000});
    tick();
    checkVal("lwEXE", {23'd0, cw()}, {23'd0, 3'b010, 6'b000000});
    checkVal("lwSrcB", {30'd0, ALUSrcB, ExtSel}, 32'd3);
    tick();
    checkVal("lwMEM", {23'd0, cw()}, {23'd0, 3'b011, 6'b000010});
    tick();
    checkVal("lwWB", {23'd0, cw()}, {23'd0, 3'b100, 6'b010100});
    checkVal("lwWbSel", {28'd0, DBDataSrc, RegDst, WrRegDSrc}, {28'd0, 4'b1011});
    tick();

    // sw: 4 cycles
    setOp(6'b110000, 1'b0, 1'b0);
    checkVal("swIF", {23'd0, cw()}, {23'd0, 3'b000, 6'b001000});
    tick();
    checkVal("swID", {23'd0, cw()}, {23'd0, 3'b001, 6'b000000});
    tick();
    checkVal("swEXE", {23'd0, cw()}, {23'd0, 3'b010, 6'b000000});
    tick();
    checkVal("swMEM", {23'd0, cw()}, {23'd0, 3'b011, 6'b010001});
    tick();
    checkVal("swDone", {29'd0, state}, 32'd0);

    // branches: 3 cycles
    for (int i = 0; i < 6; i++) begin
      setOp(brTab[i].op, brTab[i].zero, brTab[i].sign);
      tick();
      checkVal("brID", {23'd0, cw()}, {23'd0, 3'b001, 6'b000000});
      tick();
      checkVal("brEXE", {23'd0, cw()}, {23'd0, 3'b101, 6'b010000});
      checkVal("brPcSrc", {30'd0, PcSrc}, {30'd0, brTab[i].pcSrc});
      checkVal("brAluOp", {28'd0, ALUOp, ALUSrcB}, {28'd0, 4'b0010});
      tick();
      checkVal("brDone", {29'd0, state}, 32'd0);
    end

    // jumps and nop: 2 cycles
    for (int i = 0; i < 4; i++) begin
      setOp(jmpTab[i].op, 1'b0, 1'b0);
      tick();
      checkVal("jmpID", {23'd0, cw()}, {23'd0, 3'b001, 2'b01, 1'b0, jmpTab[i].regWre, 2'b00});
      checkVal("jmpSel", {27'd0, PcSrc, RegDst, WrRegDSrc},
               {27'd0, jmpTab[i].pcSrc, jmpTab[i].regDst, jmpTab[i].wrSrc});
      tick();
      checkVal("jmpDone", {23'd0, cw()}, {23'd0, 3'b000, 6'b001000});
    end

    // halt
    setOp(6'b111111, 1'b0, 1'b0);
    tick();
    checkVal("haltID", {23'd0, cw()}, {23'd0, 3'b001, 6'b000000});
    for (int i = 0; i < 10; i++) begin
      tick();
      checkVal("halted", {23'd0, cw()}, {23'd0, 3'b001, 6'b100000});
    end
    reset = 1'b0;
    #1;
    tick();
    checkVal("haltReset", {23'd0, cw()}, {23'd0, 3'b000, 6'b000000});
    reset = 1'b1;
    #1;
    checkVal("haltRelease", {23'd0, cw()}, {23'd0, 3'b000, 6'b001000});

    // reset during MEM of sw
    setOp(6'b110000, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    checkVal("abortMEM", {23'd0, cw()}, {23'd0, 3'b011, 6'b010001});
    reset = 1'b0;
    #1;
    checkVal("abortGate", {23'd0, cw()}, {23'd0, 3'b011, 6'b000000});
    tick();
    checkVal("abortState", {23'd0, cw()}, {23'd0, 3'b000, 6'b000000});
    reset = 1'b1;
    #1;
    checkVal("abortRelease", {23'd0, cw()}, {23'd0, 3'b000, 6'b001000});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
